// File: rtl/shift_seq_pkg.sv
// Shared types and sizing for the shift-register transmit sequencer.
package shift_seq_pkg;

  localparam int NBITS_DEFAULT = 8;
  localparam int DIV_W_DEFAULT = 16;

  // Width needed to count 0..nbits inclusive.
  function automatic int bit_cnt_w(input int nbits);
    return $clog2(nbits + 1);
  endfunction

  localparam int BIT_CNT_W = bit_cnt_w(NBITS_DEFAULT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    SHIFT,
    FIN
  } state_e;

endpackage

// File: rtl/shift_seq_tick.sv
// Reloadable down-counter pacing the shifts; expire is high while the count is 1.
// A load value of 0 is clamped to 1 so every bit waits at least one cycle.
module shift_seq_tick
  import shift_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             expire
);

  logic [DIV_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (value == '0) ? DIV_W'(1) : value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Transmit sequencer: loads a byte into the shift register, then paces NBITS shifts.
// Define SHIFT_SEQ_LOOPBACK_CHECK_EN to add the SR_DO loopback compare (LB_BYTE/LB_ERR).
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT,
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       BYTE_IN,
  input  logic             BYTE_VALID,
  output logic             BYTE_READY,
  input  logic             FILL,
  input  logic [DIV_W-1:0] DIV,
  output logic [7:0]       SR_PLD,
  output logic             SR_PLDEN,
  output logic             SR_EN,
  output logic             SR_DI,
  input  logic             SR_DO,
  output logic             BUSY,
  output logic             DONE
`ifdef SHIFT_SEQ_LOOPBACK_CHECK_EN
  ,
  output logic [7:0]       LB_BYTE,
  output logic             LB_ERR
`endif
);

  localparam int CW = bit_cnt_w(NBITS);

  state_e        state_d, state_q;
  logic [CW-1:0] bit_cnt_d, bit_cnt_q;
  logic [7:0]    sr_pld_d, sr_pld_q;
  logic          sr_di_d, sr_di_q;
  logic          byte_ready_d, byte_ready_q;
  logic          sr_plden_d, sr_plden_q;
  logic          sr_en_d, sr_en_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          tick_load, tick_expire;
  logic          handshake;

  assign handshake = BYTE_VALID & byte_ready_q;

  shift_seq_tick #(.DIV_W(DIV_W)) u_tick (
    .CLK    (CLK),
    .RST    (RST),
    .load   (tick_load),
    .value  (DIV),
    .expire (tick_expire)
  );

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_pld_d  = sr_pld_q;
    sr_di_d   = sr_di_q;
    tick_load = 1'b0;
    case (state_q)
      IDLE: if (handshake) begin
        sr_pld_d  = BYTE_IN;
        sr_di_d   = FILL;
        bit_cnt_d = '0;
        state_d   = LOAD;
      end
      LOAD: begin
        tick_load = 1'b1;
        state_d   = WAIT;
      end
      WAIT: if (tick_expire) state_d = SHIFT;
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_d == CW'(NBITS)) begin
          state_d = FIN;
        end else begin
          tick_load = 1'b1;
          state_d   = WAIT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the state being entered, so they align with it.
    byte_ready_d = (state_d == IDLE);
    sr_plden_d   = (state_d == LOAD);
    sr_en_d      = (state_d == SHIFT);
    done_d       = (state_d == FIN);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      sr_pld_q     <= '0;
      sr_di_q      <= 1'b0;
      byte_ready_q <= 1'b0;
      sr_plden_q   <= 1'b0;
      sr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_pld_q     <= sr_pld_d;
      sr_di_q      <= sr_di_d;
      byte_ready_q <= byte_ready_d;
      sr_plden_q   <= sr_plden_d;
      sr_en_q      <= sr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign BYTE_READY = byte_ready_q;
  assign SR_PLD     = sr_pld_q;
  assign SR_PLDEN   = sr_plden_q;
  assign SR_EN      = sr_en_q;
  assign SR_DI      = sr_di_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

`ifdef SHIFT_SEQ_LOOPBACK_CHECK_EN
  logic       shifted_d, shifted_q;
  logic [7:0] lb_byte_d, lb_byte_q;
  logic       lb_err_d, lb_err_q;

  // DO moves on the EN edge, so the cycle after SHIFT holds the bit just shifted out.
  always_comb begin
    shifted_d = (state_q == SHIFT);
    lb_byte_d = lb_byte_q;
    lb_err_d  = lb_err_q;
    if (state_q == IDLE && handshake) begin
      lb_byte_d = '0;
      lb_err_d  = 1'b0;
    end
    if (shifted_q) lb_byte_d = {lb_byte_q[6:0], SR_DO};
    if (state_q == FIN) lb_err_d = (lb_byte_d != sr_pld_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shifted_q <= 1'b0;
      lb_byte_q <= '0;
      lb_err_q  <= 1'b0;
    end else begin
      shifted_q <= shifted_d;
      lb_byte_q <= lb_byte_d;
      lb_err_q  <= lb_err_d;
    end
  end

  assign LB_BYTE = lb_byte_q;
  assign LB_ERR  = lb_err_q;
`else
  logic unused_sr_do;
  assign unused_sr_do = SR_DO;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 8-bit shift register on its outputs.
module tb_shift_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  BYTE_IN = '0;
  logic        BYTE_VALID = 1'b0;
  logic        FILL = 1'b0;
  logic [15:0] DIV = '0;
  logic        SR_DO;
  logic        BYTE_READY, SR_PLDEN, SR_EN, SR_DI, BUSY, DONE;
  logic [7:0]  SR_PLD;

  always #5 CLK = ~CLK;

  shift_seq_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .BYTE_IN    (BYTE_IN),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_READY (BYTE_READY),
    .FILL       (FILL),
    .DIV        (DIV),
    .SR_PLD     (SR_PLD),
    .SR_PLDEN   (SR_PLDEN),
    .SR_EN      (SR_EN),
    .SR_DI      (SR_DI),
    .SR_DO      (SR_DO),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  // Downstream shift register: EN has priority over PLDEN, DO registers the outgoing MSB.
  logic [7:0] sr_reg = '0;
  logic       sr_do_q = 1'b0;
  assign SR_DO = sr_do_q;
  always @(posedge CLK) begin
    if (SR_EN) begin
      sr_reg  <= {sr_reg[6:0], SR_DI};
      sr_do_q <= sr_reg[7];
    end else if (SR_PLDEN) begin
      sr_reg <= SR_PLD;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-frame observations, cycle numbers relative to the handshake cycle.
  int         en_at[8];
  int         n_en, plden_at, plden_cnt, done_at, ready_at, overlap;
  logic [7:0] do_bits, pld_at_done;
  logic       di_at_done;

  task automatic send(input logic [7:0] b, input logic [15:0] div, input logic fill);
    @(negedge CLK);
    BYTE_IN    = b;
    DIV        = div;
    FILL       = fill;
    BYTE_VALID = 1'b1;
  endtask

  task automatic watch(input bit hold, input logic [7:0] next_b, input int chg_n,
                       input logic [15:0] chg_div, input int rst_n, input int budget);
    bit prev_en  = 1'b0;
    bit chg_done = 1'b0;
    bit rst_pend = 1'b0;
    n_en = 0; plden_at = -1; plden_cnt = 0; done_at = -1; ready_at = -1; overlap = 0;
    do_bits = '0; pld_at_done = '0; di_at_done = 1'b0;
    for (int i = 0; i < 8; i++) en_at[i] = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        if (hold) BYTE_IN = next_b;
        else      BYTE_VALID = 1'b0;
        FILL = ~FILL;
      end
      if (rst_pend) begin
        RST = 1'b0;
        rst_pend = 1'b0;
        check("rst_mid_outs", {BYTE_READY, SR_PLDEN, SR_EN, SR_DI, BUSY, DONE, SR_PLD}, 0);
      end
      if (prev_en) do_bits = {do_bits[6:0], SR_DO};
      prev_en = SR_EN;
      if (SR_PLDEN) begin plden_at = k; plden_cnt++; end
      if (SR_EN) begin
        if (n_en < 8) en_at[n_en] = k;
        n_en++;
      end
      if (SR_EN && SR_PLDEN) overlap++;
      if (DONE) begin done_at = k; pld_at_done = SR_PLD; di_at_done = SR_DI; end
      if (BYTE_READY) begin ready_at = k; break; end
      if (chg_n > 0 && !chg_done && n_en == chg_n && !SR_EN) begin
        DIV = chg_div;
        chg_done = 1'b1;
      end
      if (rst_n > 0 && SR_EN && n_en == rst_n) begin
        RST = 1'b1;
        rst_pend = 1'b1;
      end
    end
    check("ready_seen", 32'(ready_at > 0), 1);
  endtask

  // Full frame with a constant effective divider d (already clamped to >= 1).
  task automatic check_uniform(input int d, input logic [7:0] b, input logic fill);
    check("plden_at", plden_at, 1);
    check("plden_cnt", plden_cnt, 1);
    check("en_count", n_en, 8);
    for (int i = 0; i < 8; i++) check("en_at", en_at[i], 1 + (i + 1) * (d + 1));
    check("done_at", done_at, 2 + 8 * (d + 1));
    check("ready_at", ready_at, 3 + 8 * (d + 1));
    check("overlap", overlap, 0);
    check("do_bits", do_bits, b);
    check("pld_hold", pld_at_done, b);
    check("di_hold", di_at_done, fill);
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_outs", {BYTE_READY, SR_PLDEN, SR_EN, SR_DI, BUSY, DONE, SR_PLD}, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", BYTE_READY, 1);
    check("busy_after_rst", BUSY, 0);

    // 0xA5, DIV=3
    send(8'hA5, 16'd3, 1'b0);
    watch(1'b0, 8'h00, 0, 16'd0, 0, 200);
    check_uniform(3, 8'hA5, 1'b0);

    // DIV=0 behaves as DIV=1
    send(8'hFF, 16'd0, 1'b1);
    watch(1'b0, 8'h00, 0, 16'd0, 0, 200);
    check_uniform(1, 8'hFF, 1'b1);

    // BYTE_VALID held with 0x3C during a busy frame; FILL toggled to 1 at k=1
    send(8'h5A, 16'd1, 1'b0);
    watch(1'b1, 8'h3C, 0, 16'd0, 0, 200);
    check_uniform(1, 8'h5A, 1'b0);
    watch(1'b0, 8'h00, 0, 16'd0, 0, 200);
    check_uniform(1, 8'h3C, 1'b1);

    // DIV 2 -> 5 after the 3rd EN: four bits of period 3, then four of period 6
    send(8'h81, 16'd2, 1'b0);
    watch(1'b0, 8'h00, 3, 16'd5, 0, 200);
    check("chg_en0", en_at[0], 4);
    check("chg_en2", en_at[2], 10);
    check("chg_en3", en_at[3], 13);
    check("chg_en4", en_at[4], 19);
    check("chg_en7", en_at[7], 37);
    check("chg_done", done_at, 38);
    check("chg_ready", ready_at, 39);
    check("chg_do", do_bits, 8'h81);

    // RST for one cycle after the 4th EN
    send(8'hC3, 16'd1, 1'b0);
    watch(1'b0, 8'h00, 0, 16'd0, 4, 100);
    check("rst_en_cnt", n_en, 4);
    check("rst_no_done", done_at, -1);
    check("rst_ready", ready_at, 11);

    // DIV at maximum: first bit period is 2^16 cycles
    send(8'h11, 16'hFFFF, 1'b0);
    watch(1'b0, 8'h00, 0, 16'd0, 1, 70000);
    check("max_en0", en_at[0], 65537);
    check("max_ready", ready_at, 65539);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Transmit sequencer that sits directly upstream of the 8-bit serial/parallel shift register and drives its DI, EN, PLD and PLDEN inputs.
- Accepts a byte from the 8051-side logic over a valid/ready handshake and parallel-loads it into the shift register.
- Then issues eight single-cycle shift enables, one every DIV+1 clocks, so the register's DO line emits the byte MSB first.
- Signals completion with a one-cycle pulse and returns to idle.

Parameters:
- DIV_W, 16, width of the per-bit wait count DIV.
- NBITS, 8, shifts per frame; must equal the shift register width.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- BYTE_IN  in  8  byte to send.
- BYTE_VALID  in  1  BYTE_IN valid.
- BYTE_READY  out  1  controller can accept a byte.
- FILL  in  1  serial fill bit shifted into the register's low end.
- DIV  in  DIV_W  wait cycles between shifts; 0 is treated as 1.
- SR_PLD  out  8  to shift register PLD.
- SR_PLDEN  out  1  to shift register PLDEN.
- SR_EN  out  1  to shift register EN.
- SR_DI  out  1  to shift register DI.
- SR_DO  in  1  from shift register DO; used only with the optional feature.
- BUSY  out  1  frame in progress.
- DONE  out  1  one-cycle pulse when the frame completes.

Behaviour:
- One clock, CLK. Reset is synchronous, active-high, on RST.
- All outputs are registered.
- Reset values:
  - BYTE_READY=0 during RST, then 1 from the first cycle after RST deasserts.
  - SR_PLD=0, SR_PLDEN=0, SR_EN=0, SR_DI=0, BUSY=0, DONE=0.
  - Internal state IDLE; bit count 0; wait counter 0.
- States: IDLE, LOAD, WAIT, SHIFT, FIN.
- IDLE:
  - BYTE_READY=1, BUSY=0.
  - Handshake occurs when BYTE_VALID & BYTE_READY in cycle t.
  - On handshake: SR_PLD<=BYTE_IN, SR_DI<=FILL, bit count<=0, go to LOAD.
- LOAD (cycle t+1):
  - SR_PLDEN=1, SR_EN=0, BYTE_READY=0, BUSY=1.
  - Wait counter<=max(DIV,1). Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to SHIFT.
  - This gives exactly max(DIV,1) cycles in WAIT.
- SHIFT:
  - SR_EN=1 for exactly one cycle; SR_PLDEN=0; bit count++.
  - If bit count becomes NBITS, go to FIN.
  - Otherwise reload the counter with max(DIV,1) and return to WAIT.
  - DIV is resampled at each reload; mid-frame DIV changes take effect on the next bit.
- FIN:
  - DONE=1 for one cycle, BUSY still 1.
  - Then go to IDLE; BYTE_READY=1 the following cycle.
- Frame length from handshake edge to first IDLE cycle: 2 + NBITS*(max(DIV,1)+1) cycles.
- SR_PLDEN and SR_EN are never asserted in the same cycle. The register gives EN priority, so the controller must keep them mutually exclusive.
- BYTE_VALID while BYTE_READY=0 is ignored; the upstream holds its byte until accepted.
- SR_PLD and SR_DI stay stable for the whole frame. FILL changes mid-frame have no effect.
- RST asserted mid-frame:
  - Returns to IDLE with reset output values on the next edge; the frame is abandoned.
  - No DONE pulse is generated.
  - The shift register contents are not restored.
- DIV at maximum (2^DIV_W-1): no counter overflow; per-bit period is 2^DIV_W cycles.

Optional Feature:
- Macro: SHIFT_SEQ_LOOPBACK_CHECK_EN.
- With the macro defined, add outputs LB_BYTE [7:0] and LB_ERR [1]:
  - Sample SR_DO in the cycle after each SHIFT and shift it into LB_BYTE LSB-first, so LB_BYTE ends up holding bits in arrival order, MSB of the sent byte ending at bit 7.
  - Because DO updates on the same edge as EN, the post-SHIFT cycle sample is the bit just shifted out.
  - In FIN, LB_ERR<=(LB_BYTE != SR_PLD). It stays valid until the next handshake, which clears it.
  - Both outputs reset to 0.
- Without the macro: no SR_DO logic, no extra ports; SR_DO is left unconnected internally.

Decomposition:
- Package shift_seq_pkg:
  - state enum {IDLE, LOAD, WAIT, SHIFT, FIN}.
  - NBITS_DEFAULT=8, DIV_W_DEFAULT=16.
  - Localparam for the bit-count width, clog2(NBITS+1).
- One natural sub-module: shift_seq_tick, the reloadable down-counter.
  - Inputs: load, value.
  - Output: expire pulse when the count reaches 1.
  - Owns the DIV=0→1 clamp.

Test Plan:
- Reset then send 0xA5 with DIV=3, FILL=0:
  - PLDEN at t+1.
  - EN pulses at t+5, t+9, ..., t+33.
  - DONE at t+34; BYTE_READY at t+35.
  - SR_DO sequence 1,0,1,0,0,1,0,1.
- DIV=0 with byte 0xFF:
  - EN every 2 cycles, behaving identically to DIV=1.
  - Frame length 18 cycles.
- Hold BYTE_VALID high with a new byte 0x3C during a busy frame:
  - Not accepted until IDLE.
  - Accepted the cycle after DONE+1; second frame starts immediately.
- Assert RST for one cycle after the 4th EN:
  - All outputs 0 next cycle.
  - No DONE.
  - BYTE_READY=1 the cycle after RST deasserts.
- Change DIV from 2 to 5 after the 3rd EN:
  - Gap before the 4th EN is 3 cycles if reloaded earlier, 6 cycles from the next reload on.
  - Total matches the formula.
- With SHIFT_SEQ_LOOPBACK_CHECK_EN and a real shift register attached:
  - Send 0x96: LB_BYTE=0x96, LB_ERR=0.
  - Force SR_DO stuck at 0: LB_ERR=1 in FIN.
